// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and sizing helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    function automatic int frame_len(input int width, input bit parity);
        return width + (parity ? 1 : 0);
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: valid/ready parallel word in, one bit per clock out, back-to-back capable.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_bit_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(frame_len(WIDTH, PAR_EN) - 1);

    piso_state_t      state, state_n;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             accept, next_bit, shifting;

    assign data_ready = (state == IDLE) || (cnt == '0);
    assign accept     = data_valid && data_ready;
    assign shifting   = (state == SHIFT) && (cnt != '0);

`ifdef PISO_SERIALIZER_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (rst)
            par <= 1'b0;
        else if (accept)
            par <= ^data_in;
    end

    // All data bits have left the register by the time one bit remains.
    always_comb begin
        state_n  = (accept || shifting) ? SHIFT : IDLE;
        next_bit = (cnt == CW'(1)) ? par : (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
    end
`else
    always_comb begin
        state_n  = (accept || shifting) ? SHIFT : IDLE;
        next_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    end
`endif

    // The first bit goes straight from data_in so it appears the cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            serial_out  <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            frame_start <= accept;
            bit_valid   <= state_n == SHIFT;
            busy        <= state_n == SHIFT;
            if (accept) begin
                sr         <= MSB_FIRST ? data_in << 1 : data_in >> 1;
                cnt        <= LAST;
                serial_out <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            end else if (shifting) begin
                sr         <= MSB_FIRST ? sr << 1 : sr >> 1;
                cnt        <= cnt - CW'(1);
                serial_out <= next_bit;
            end else begin
                serial_out <= 1'b0;
            end
        end
    end

endmodule
